kernel_ad_in_pio: RTL

//  Avalon-MM slave input port: the read-side counterpart of the kernel's output PIOs.

---
 rtl/kernel_ad_in_pio.sv | 87 ++++++++
 1 files changed

// File: rtl/kernel_ad_in_pio.sv
// Avalon-MM input PIO: synchronizes an external bus, captures per-bit edges (sticky, W1C), maskable irq.
// Read latency 1 clk, input-to-d_sync SYNC_STAGES clks; no backpressure, always ready.
module kernel_ad_in_pio #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0,
    parameter int IRQ_TYPE    = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] d_sync;
    logic [WIDTH-1:0] d_prev;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] capture;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] clr;
    logic             write_en;
    logic [31:0]      rd_mux;
    logic             unused_wdata;

    assign unused_wdata = ^writedata;
    assign d_sync       = sync_q[SYNC_STAGES-1];
    assign write_en     = chipselect & ~write_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            d_prev <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
            d_prev <= d_sync;
        end
    end

    always_comb begin
        edge_det = '0;
        case (EDGE_TYPE)
            0:       edge_det = d_sync & ~d_prev;
            1:       edge_det = ~d_sync & d_prev;
            default: edge_det = d_sync ^ d_prev;
        endcase
    end

    always_comb begin
        clr = '0;
        if (write_en && address == 2'd3) clr = writedata[WIDTH-1:0];
    end

    // A fresh edge always survives a same-cycle clear so no event is lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask    <= '0;
            capture <= '0;
        end else begin
            if (write_en && address == 2'd2) mask <= writedata[WIDTH-1:0];
            capture <= edge_det | (capture & ~clr);
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0:    rd_mux[WIDTH-1:0] = d_sync;
            2'd2:    rd_mux[WIDTH-1:0] = mask;
            2'd3:    rd_mux[WIDTH-1:0] = capture;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata <= '0;
        else          readdata <= rd_mux;
    end

    assign irq = (IRQ_TYPE == 0) ? |(d_sync & mask) : |(capture & mask);

endmodule
